// File: rtl/systolic_seq.sv
// rtl/systolic_seq.sv - command sequencer driving the 2x2 systolic array over ibus
module systolic_seq #(
    parameter logic [15:0] ADR_FIFO  = 16'h0000,
    parameter logic [15:0] ADR_CNT   = 16'h0004,
    parameter logic [15:0] ADR_START = 16'h0005,
    parameter logic [15:0] ADR_STAT  = 16'h0006,
    parameter logic [15:0] ADR_RES   = 16'h0008,
    parameter logic [15:0] POLL_MAX  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_len,
    input  logic [15:0] cmd_src,
    input  logic [15:0] cmd_dst,
    output logic        done,
    output logic        err,
    output logic        sat,
    output logic        mem_ren,
    output logic [15:0] mem_radr,
    input  logic [15:0] mem_rdata,
    output logic        mem_wen,
    output logic [15:0] mem_wadr,
    output logic [15:0] mem_wdata,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CFG, S_START, S_POLL, S_DRAIN, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  len_r;
    logic [15:0] dst_r;
    logic [15:0] rd_adr;
    logic [1:0]  q;
    logic [7:0]  j;
    logic        rd_done;
    logic        pend_valid;
    logic [1:0]  pend_q;
    logic [15:0] poll_cnt;
    logic        poll_phase;
    logic [2:0]  drain_idx;
    logic        sat_pend;
    logic        err_r, sat_r;

    assign err = err_r;
    assign sat = sat_r;

    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        mem_ren    = 1'b0;
        mem_radr   = 16'h0000;
        mem_wen    = 1'b0;
        mem_wadr   = 16'h0000;
        mem_wdata  = 16'h0000;
        ren        = 1'b0;
        ibus_radr  = 16'h0000;
        wen        = 1'b0;
        ibus_wadr  = 16'h0000;
        ibus_wdata = 16'h0000;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (!rd_done) begin
                    mem_ren  = 1'b1;
                    mem_radr = rd_adr;
                end
                // memory word returned for last cycle's read goes straight to its FIFO
                if (pend_valid) begin
                    wen        = 1'b1;
                    ibus_wadr  = ADR_FIFO + {14'd0, pend_q};
                    ibus_wdata = mem_rdata;
                end
                if (rd_done) state_nx = (len_r == 8'd0) ? S_DONE : S_CFG;
            end
            S_CFG: begin
                wen        = 1'b1;
                ibus_wadr  = ADR_CNT;
                ibus_wdata = {8'h00, len_r};
                state_nx   = S_START;
            end
            S_START: begin
                wen        = 1'b1;
                ibus_wadr  = ADR_START;
                ibus_wdata = 16'h0001;
                state_nx   = S_POLL;
            end
            S_POLL: begin
                if (!poll_phase) begin
                    ren       = 1'b1;
                    ibus_radr = ADR_STAT;
                end else if (ibus_rdata[0]) begin
                    state_nx = S_DRAIN;
                end else if (poll_cnt == POLL_MAX) begin
                    state_nx = S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_idx < 3'd4) begin
                    ren       = 1'b1;
                    ibus_radr = ADR_RES + {13'd0, drain_idx};
                end
                if (drain_idx != 3'd0) begin
                    mem_wen   = 1'b1;
                    mem_wadr  = dst_r + {13'd0, drain_idx} - 16'd1;
                    mem_wdata = ibus_rdata;
                end
                if (drain_idx == 3'd4) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_r      <= 8'd0;
            dst_r      <= 16'h0000;
            rd_adr     <= 16'h0000;
            q          <= 2'd0;
            j          <= 8'd0;
            rd_done    <= 1'b0;
            pend_valid <= 1'b0;
            pend_q     <= 2'd0;
            poll_cnt   <= 16'd0;
            poll_phase <= 1'b0;
            drain_idx  <= 3'd0;
            sat_pend   <= 1'b0;
            err_r      <= 1'b0;
            sat_r      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        len_r      <= cmd_len;
                        dst_r      <= cmd_dst;
                        rd_adr     <= cmd_src;
                        q          <= 2'd0;
                        j          <= 8'd0;
                        // a zero-length command spends its single LOAD cycle idle
                        rd_done    <= (cmd_len == 8'd0);
                        pend_valid <= 1'b0;
                        poll_cnt   <= 16'd0;
                        poll_phase <= 1'b0;
                        drain_idx  <= 3'd0;
                        sat_pend   <= 1'b0;
                        err_r      <= 1'b0;
                        sat_r      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    pend_valid <= !rd_done;
                    pend_q     <= q;
                    if (!rd_done) begin
                        rd_adr <= rd_adr + 16'd1;
                        if (j == len_r - 8'd1) begin
                            j <= 8'd0;
                            q <= q + 2'd1;
                            if (q == 2'd3) rd_done <= 1'b1;
                        end else begin
                            j <= j + 8'd1;
                        end
                    end
                end
                S_POLL: begin
                    poll_phase <= !poll_phase;
                    if (!poll_phase) poll_cnt <= poll_cnt + 16'd1;
                    else if (ibus_rdata[0]) sat_pend <= sat_pend | ibus_rdata[1];
                end
                S_DRAIN: drain_idx <= drain_idx + 3'd1;
                default: ;
            endcase
            // err/sat are published only on the edge that enters DONE
            if (state != S_DONE && state_nx == S_DONE) begin
                err_r <= (state != S_DRAIN);
                sat_r <= (state == S_DRAIN) ? sat_pend : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// tb/tb_systolic_seq.sv - self-checking bench for systolic_seq with memory and array stubs
module tb_systolic_seq;

    localparam int PM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = 8'd0;
    logic [15:0] cmd_src = 16'h0000;
    logic [15:0] cmd_dst = 16'h0000;
    logic        done, err, sat;
    logic        mem_ren, mem_wen, ren, wen;
    logic [15:0] mem_radr, mem_wadr, mem_wdata, ibus_radr, ibus_wadr, ibus_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] ibus_rdata = 16'h0000;

    systolic_seq #(.POLL_MAX(16'(PM))) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .done(done), .err(err), .sat(sat),
        .mem_ren(mem_ren), .mem_radr(mem_radr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_wadr(mem_wadr), .mem_wdata(mem_wdata),
        .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
        .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] adr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int cyc;
        int e;
        int s;
    } done_t;

    typedef struct {
        int          len;
        logic [15:0] src;
        logic [15:0] dst;
        int          da;
        logic [15:0] sv;
        int          lat;
        int          e;
        int          s;
        int          polls;
    } vec_t;

    logic [15:0] mem [0:65535];
    logic [15:0] res [0:3];
    int          done_after = 0;
    logic [15:0] stat_val = 16'h0000;
    int          polls = 0;
    int          cyc = 0;
    int          stat_reads = 0;
    int          conflicts = 0;
    wr_t         wq[$];
    wr_t         mwq[$];
    logic [15:0] mrq[$];
    done_t       dq[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_radr];

    // array stub: status turns done on the done_after-th read after START
    always @(posedge clk) begin
        if (wen && ibus_wadr == 16'h0005) polls <= 0;
        if (ren) begin
            if (ibus_radr == 16'h0006) begin
                polls <= polls + 1;
                ibus_rdata <= (done_after != 0 && polls + 1 >= done_after) ? stat_val : 16'h0000;
            end else if (ibus_radr >= 16'h0008 && ibus_radr < 16'h000C) begin
                ibus_rdata <= res[ibus_radr[1:0]];
            end else begin
                ibus_rdata <= 16'hDEAD;
            end
        end
    end

    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (wen) begin
            w.cyc = cyc; w.adr = ibus_wadr; w.data = ibus_wdata; wq.push_back(w);
        end
        if (mem_wen) begin
            w.cyc = cyc; w.adr = mem_wadr; w.data = mem_wdata; mwq.push_back(w);
        end
        if (mem_ren) mrq.push_back(mem_radr);
        if (ren && ibus_radr == 16'h0006) stat_reads = stat_reads + 1;
        if (ren && wen) conflicts = conflicts + 1;
        if (done) begin
            d.cyc = cyc; d.e = int'(err); d.s = int'(sat); dq.push_back(d);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input int len, input int da, input logic [15:0] sv,
                                  output int lat, output int e, output int s, output int np);
        if (len == 0) begin
            lat = 2; e = 1; s = 0; np = 0;
        end else if (da != 0 && da <= PM) begin
            lat = 4 * len + 2 * da + 9; e = 0; s = int'(sv[1]); np = da;
        end else begin
            lat = 4 * len + 2 * PM + 4; e = 1; s = 0; np = PM;
        end
    endfunction

    task automatic run_cmd(input vec_t v, input bit rnd);
        int          c0, w0, r0, m0, s0, d0, n, k, idx;
        logic [15:0] a;
        wr_t         exp_w[$];
        wr_t         e;
        for (int i = 0; i < 4 * v.len; i++) begin
            a = 16'(v.src + 16'(i));
            mem[a] = rnd ? 16'($urandom) : 16'(i + 1);
        end
        for (int i = 0; i < 4; i++) res[i] = rnd ? 16'($urandom) : 16'(16'h000A + i);
        done_after = v.da;
        stat_val = v.sv;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        w0 = wq.size(); r0 = mrq.size(); m0 = mwq.size(); s0 = stat_reads; d0 = dq.size();
        cmd_len = 8'(v.len); cmd_src = v.src; cmd_dst = v.dst; cmd_valid = 1'b1; c0 = cyc;
        @(negedge clk);
        chk("busy_ready_low", 32'(cmd_ready), 32'd0);
        chk("err_clear_on_accept", 32'(err), 32'd0);
        chk("sat_clear_on_accept", 32'(sat), 32'd0);
        cmd_src = ~v.src; cmd_len = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        n = 0;
        while (dq.size() == d0 && n < 3000) begin @(negedge clk); #1; n++; end
        if (dq.size() == d0) begin
            chk("done_wait", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(dq[d0].cyc - c0), 32'(v.lat));
        chk("err", 32'(dq[d0].e), 32'(v.e));
        chk("sat", 32'(dq[d0].s), 32'(v.s));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after_done", 32'(cmd_ready), 32'd1);
        chk("status_reads", 32'(stat_reads - s0), 32'(v.polls));
        if (v.len > 0) begin
            k = 0;
            for (int qq = 0; qq < 4; qq++)
                for (int jj = 0; jj < v.len; jj++) begin
                    e.adr = 16'(qq);
                    e.data = mem[16'(v.src + 16'(qq * v.len + jj))];
                    e.cyc = c0 + 2 + k;
                    exp_w.push_back(e);
                    k++;
                end
            e.adr = 16'h0004; e.data = 16'(v.len); e.cyc = c0 + 4 * v.len + 2; exp_w.push_back(e);
            e.adr = 16'h0005; e.data = 16'h0001; e.cyc = c0 + 4 * v.len + 3; exp_w.push_back(e);
        end
        chk("ibus_write_count", 32'(wq.size() - w0), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && w0 + i < wq.size(); i++) begin
            idx = w0 + i;
            chk($sformatf("ibus_wr[%0d]", i), {wq[idx].adr, wq[idx].data}, {exp_w[i].adr, exp_w[i].data});
            chk($sformatf("ibus_wr_cycle[%0d]", i), 32'(wq[idx].cyc - c0), 32'(exp_w[i].cyc - c0));
        end
        chk("mem_read_count", 32'(mrq.size() - r0), 32'(4 * v.len));
        for (int i = 0; i < 4 * v.len && r0 + i < mrq.size(); i++)
            chk($sformatf("mem_radr[%0d]", i), 32'(mrq[r0 + i]), 32'(16'(v.src + 16'(i))));
        chk("mem_write_count", 32'(mwq.size() - m0), (v.e == 0) ? 32'd4 : 32'd0);
        if (v.e == 0)
            for (int i = 0; i < 4 && m0 + i < mwq.size(); i++)
                chk($sformatf("mem_wr[%0d]", i), {mwq[m0 + i].adr, mwq[m0 + i].data},
                    {16'(v.dst + 16'(i)), res[i]});
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_strobes", {28'd0, done, err, sat, mem_ren}, 32'd0);
        chk("rst_wstrobes", {29'd0, mem_wen, ren, wen}, 32'd0);
        chk("rst_addr", {mem_radr, mem_wadr}, 32'd0);
        chk("rst_ibus_addr", {ibus_radr, ibus_wadr}, 32'd0);
        chk("rst_data", {mem_wdata, ibus_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back('{1, 16'h0100, 16'h0200, 2, 16'h0001, 17, 0, 0, 2});
        tbl.push_back('{2, 16'h0400, 16'h0500, 1, 16'h0001, 19, 0, 0, 1});
        tbl.push_back('{3, 16'h0600, 16'h0700, 3, 16'h0003, 27, 0, 1, 3});
        tbl.push_back('{1, 16'h0800, 16'h0900, 1, 16'h0001, 15, 0, 0, 1});
        tbl.push_back('{0, 16'h1000, 16'h1100, 1, 16'h0001, 2, 1, 0, 0});
        tbl.push_back('{1, 16'h1200, 16'h1300, 0, 16'h0001, 16, 1, 0, 4});
        tbl.push_back('{2, 16'hFFFC, 16'hFFFE, 2, 16'h0003, 21, 0, 1, 2});
        tbl.push_back('{1, 16'h1400, 16'h1500, 4, 16'h0001, 21, 0, 0, 4});
        foreach (tbl[i]) run_cmd(tbl[i], 1'b0);

        // reset in the middle of LOAD, while the j=1 read is on the bus
        while (!cmd_ready) @(negedge clk);
        cmd_len = 8'd3; cmd_src = 16'h0200; cmd_dst = 16'h0300; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_load_reading", 32'(mem_radr), 32'h0201);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_strobes", {28'd0, mem_ren, wen, ren, mem_wen}, 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{3, 16'h0200, 16'h0300, 2, 16'h0001, 0, 0, 0, 0};
        model(v.len, v.da, v.sv, v.lat, v.e, v.s, v.polls);
        run_cmd(v, 1'b1);

        for (int i = 0; i < 20; i++) begin
            v.len = (i % 7 == 3) ? 0 : $urandom_range(1, 6);
            v.src = 16'($urandom);
            v.dst = 16'($urandom);
            if (i % 5 == 1) v.src = 16'hFFF8;
            v.da = $urandom_range(0, 6);
            v.sv = 16'h0001 | (16'($urandom_range(0, 1)) << 1);
            model(v.len, v.da, v.sv, v.lat, v.e, v.s, v.polls);
            run_cmd(v, 1'b1);
        end

        chk("ren_wen_exclusive", 32'(conflicts), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
# systolic_seq

Command-driven sequencer for the 2x2 systolic array. It owns the array's ibus master port: it copies operand words from a local memory into the four PE input FIFOs, programs the iteration count, and starts the run. It then polls for completion and copies the four results back to memory. It sits between the CPU-side command registers / scratch RAM and the systolic array top.

## Interface
Parameters:
- ADR_FIFO, 16'h0000: ibus base of input FIFOs; +0 A row0, +1 A row1, +2 B col0, +3 B col1
- ADR_CNT, 16'h0004: ibus address of max_cntr register
- ADR_START, 16'h0005: ibus address of start register (write 1 to start)
- ADR_STAT, 16'h0006: ibus status; bit0 = done, bit1 = saturation
- ADR_RES, 16'h0008: ibus base of results s00, s01, s10, s11 (+0..+3)
- POLL_MAX, 16'd1024: max status reads before timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  8  K, inner dimension (1..255)
- cmd_src  in  16  memory base of operands
- cmd_dst  in  16  memory base of results
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; held until next accept
- sat  out  1  valid with done; held until next accept
- mem_ren / mem_radr / mem_rdata  out 1 / out 16 / in 16  memory read port, 1-cycle read latency
- mem_wen / mem_wadr / mem_wdata  out 1 / out 16 / out 16  memory write port
- ren / ibus_radr / ibus_rdata  out 1 / out 16 / in 16  array read port, 1-cycle latency
- wen / ibus_wadr / ibus_wdata  out 1 / out 16 / out 16  array write port

## Operation
- States: IDLE, LOAD, CFG, START, POLL, DRAIN, DONE.
- IDLE: accept on cmd_valid & cmd_ready. Latch len/src/dst and clear err and sat.
  - If len==0: go to DONE with err=1 and no bus activity.
- Operand layout: A0 at src+0..K-1, A1 at src+K.., B0 at src+2K.., B1 at src+3K...
- LOAD: issue 4K mem reads at consecutive addresses, one per cycle. Counters are q (0..3) and j (0..K-1).
  - Each returned word is written one cycle later to ibus ADR_FIFO+q.
- CFG: one write of {8'h00,len} to ADR_CNT.
- START: one write of 16'h0001 to ADR_START.
- POLL: read ADR_STAT, examine rdata the next cycle, repeat. A read is issued every 2nd cycle.
  - bit0=1 → DRAIN, with sat |= bit1.
  - After POLL_MAX reads without done → DONE with err=1.
- DRAIN: 4 back-to-back reads of ADR_RES+0..3. Each rdata is written one cycle later to mem dst+0..3.
- DONE: done=1 for one cycle → IDLE.
- Address arithmetic is 16-bit and wraps modulo 2^16 (src+4K-1 and dst+3 may wrap).
- cmd_valid while not in IDLE is ignored; no queueing.
- wen and ren are never both high in the same cycle.

## Timing
- Reset values: cmd_ready=1 and state=IDLE. All other outputs are 0: done, err, sat, mem_ren, mem_wen, ren, wen, and all address/data outputs.
- Accept in cycle 0 → first mem_ren in cycle 1, first ibus wen in cycle 2.
- LOAD lasts 4K+1 cycles, and ibus writes are contiguous. CFG and START take one cycle each.
- POLL with done seen on the n-th read: 2n cycles. DRAIN: 5 cycles. DONE: 1 cycle.
- Minimum total latency, accept to done, is 4K+2n+9 cycles.
- Reset mid-operation: bus strobes drop asynchronously and the FSM returns to IDLE. Partial FIFO contents in the array are not cleaned up; the array shares rst_n.
- err/sat change only on accept and at DONE.

## Test plan
- K=1, src=0x0100, mem[0x100..0x103]=1,2,3,4; array stub sets done on the 2nd poll → ibus writes (0x0000,1), (0x0001,2), (0x0002,3), (0x0003,4), (0x0004,1), (0x0005,1). Two status reads. Results 0x0A,0x0B,0x0C,0x0D land at dst..dst+3. done at cycle 17, err=0.
- K=2, A0=[1,2], A1=[3,4], B0=[5,6], B1=[7,8] → FIFO write order 1,2,3,4,5,6,7,8 to addresses 0,0,1,1,2,2,3,3 on 8 consecutive cycles; CNT write is 2.
- Stub status returns 16'h0003 → sat=1 with done; next command clears sat at accept.
- cmd_len=0 → done pulses 2 cycles after accept with err=1; no ren/wen/mem strobes.
- Status never done with POLL_MAX=4 → exactly 4 status reads, then done with err=1, no DRAIN writes.
- Assert rst_n low mid-LOAD at j=1, then issue a new command → cmd_ready=1 after reset, and the new sequence restarts from src+0.
